wb_sram: RTL and testbench

WB_SRAM -- requirements
Module: wb_sram

---
 rtl/wb_pkg.sv | 34 +++
 rtl/wb_if.sv | 29 ++
 rtl/wb_sram_mem.sv | 43 ++++
 rtl/wb_sram.sv | 123 ++++++++++++
 tb/tb_wb_sram.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone B4 types: cycle/burst type encodings and the SRAM slave FSM states.
package wb_pkg;

    typedef enum logic [2:0] {
        CLASSIC = 3'b000,
        CONST   = 3'b001,
        INCR    = 3'b010,
        END     = 3'b111
    } cti_e;

    typedef enum logic [1:0] {
        LINEAR = 2'b00,
        WRAP4  = 2'b01,
        WRAP8  = 2'b10,
        WRAP16 = 2'b11
    } bte_e;

    typedef enum logic [1:0] {
        IDLE,
        SINGLE,
        BURST
    } wb_sram_state_e;

    // Number of low word-index bits that wrap for a given burst type; 0 means linear.
    function automatic int unsigned bte_wrap_bits(bte_e bte);
        case (bte)
            LINEAR:  return 0;
            WRAP4:   return 2;
            WRAP8:   return 3;
            default: return 4;
        endcase
    endfunction

endpackage

// File: rtl/wb_if.sv
// Wishbone B4 signal bundle with master and slave views.
interface wb_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic [ADDR_WIDTH-1:0]   adr;
    logic [DATA_WIDTH-1:0]   dat_w;
    logic [DATA_WIDTH-1:0]   dat_r;
    logic [DATA_WIDTH/8-1:0] sel;
    logic                    cyc;
    logic                    stb;
    logic                    we;
    logic [2:0]              cti;
    logic [1:0]              bte;
    logic                    ack;
    logic                    err;

    modport slave (
        input  adr, dat_w, sel, cyc, stb, we, cti, bte,
        output dat_r, ack, err
    );

    modport master (
        output adr, dat_w, sel, cyc, stb, we, cti, bte,
        input  dat_r, ack, err
    );

endinterface

// File: rtl/wb_sram_mem.sv
// Single-port RAM with synchronous write-first read and per-byte write enables.
module wb_sram_mem #(
    parameter int unsigned ADDR_BITS  = 10,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_BITS-1:0]    addr_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    localparam int unsigned NumBytes = DATA_WIDTH / 8;
    localparam int unsigned Depth    = 1 << ADDR_BITS;

    logic [DATA_WIDTH-1:0] mem_q [Depth];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < NumBytes; b++) begin
            if (we_i && be_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    // Written lanes bypass the array so a same-cycle read sees the new bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            for (int unsigned b = 0; b < NumBytes; b++) begin
                rdata_q[8*b +: 8] <= (we_i && be_i[b]) ? wdata_i[8*b +: 8]
                                                       : mem_q[addr_i][8*b +: 8];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_sram.sv
// Wishbone B4 registered-feedback SRAM slave: classic cycles with one wait state,
// zero-wait incrementing/wrapping bursts driven by an internal address predictor.
module wb_sram
    import wb_pkg::*;
#(
    parameter int unsigned              WB_ADDR_WIDTH = 32,
    parameter int unsigned              WB_DATA_WIDTH = 32,
    parameter int unsigned              MEM_ADDR_BITS = 10,
    parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR     = '0
) (
    input logic clk,
    input logic rst,
    wb_if.slave s
);

    localparam int unsigned OffBits  = (WB_DATA_WIDTH == 64) ? 3 : 2;
    localparam int unsigned RangeLsb = MEM_ADDR_BITS + OffBits;

    typedef logic [MEM_ADDR_BITS-1:0] idx_t;

    wb_sram_state_e state_q, state_d;
    logic           ack_q, ack_d;
    logic           err_q, err_d;
    idx_t           cur_q, cur_d;
    idx_t           idx, nxt, mem_idx;
    logic           req, in_range, beat_ok, wr_en;
    logic [WB_DATA_WIDTH-1:0] rdata;
    logic           unused_adr;

    function automatic idx_t burst_next(idx_t cur, logic [1:0] bte);
        int unsigned bits;
        idx_t        mask;
        bits = bte_wrap_bits(bte_e'(bte));
        mask = (bits == 0) ? '1 : (idx_t'(1) << bits) - idx_t'(1);
        return (cur & ~mask) | ((cur + idx_t'(1)) & mask);
    endfunction

    assign req        = s.cyc & s.stb;
    assign idx        = s.adr[RangeLsb-1:OffBits];
    assign unused_adr = ^s.adr[OffBits-1:0];
    // BASE_ADDR is aligned to the memory size, so the range check is a tag compare.
    assign in_range   = s.adr[WB_ADDR_WIDTH-1:RangeLsb] == BASE_ADDR[WB_ADDR_WIDTH-1:RangeLsb];
    assign nxt        = burst_next(cur_q, s.bte);

    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        cur_d   = cur_q;
        mem_idx = idx;
        beat_ok = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req && (s.cti == CLASSIC || s.cti == END)) begin
                    state_d = SINGLE;
                    ack_d   = in_range;
                    err_d   = ~in_range;
                end else if (req && s.cti == INCR) begin
                    state_d = in_range ? BURST : SINGLE;
                    ack_d   = in_range;
                    err_d   = ~in_range;
                    cur_d   = idx;
                end
            end
            SINGLE: begin
                state_d = IDLE;
                beat_ok = 1'b1;
            end
            BURST: begin
                beat_ok = req && (idx == cur_q) && (s.cti == INCR || s.cti == END);
                if (beat_ok && s.cti == INCR) begin
                    ack_d = 1'b1;
                    cur_d = nxt;
                    // Prefetch the next beat so reads sustain one word per cycle.
                    if (!s.we) begin
                        mem_idx = nxt;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!s.cyc) begin
            state_d = IDLE;
            ack_d   = 1'b0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            cur_q   <= cur_d;
        end
    end

    assign s.ack   = ack_q & req;
    assign s.err   = err_q & req;
    assign s.dat_r = rdata;
    assign wr_en   = s.ack & s.we & beat_ok & ~rst;

    wb_sram_mem #(
        .ADDR_BITS  (MEM_ADDR_BITS),
        .DATA_WIDTH (WB_DATA_WIDTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .addr_i  (mem_idx),
        .we_i    (wr_en),
        .be_i    (s.sel),
        .wdata_i (s.dat_w),
        .rdata_o (rdata)
    );

endmodule

// File: tb/tb_wb_sram.sv
// Directed bench for wb_sram: classic, byte-select, burst, wrap, error and abort scenarios.
module tb_wb_sram;
    import wb_pkg::*;

    localparam logic [31:0] Base = 32'h0000_1000;
    localparam logic [31:0] OutOfRange = Base + (32'd4 << 10);

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    wb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    wb_sram #(
        .WB_ADDR_WIDTH (32),
        .WB_DATA_WIDTH (32),
        .MEM_ADDR_BITS (10),
        .BASE_ADDR     (Base)
    ) dut (
        .clk (clk),
        .rst (rst),
        .s   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [2:0] cti, input logic [1:0] bte,
                         input logic w, input logic [31:0] d);
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.adr = a; bus.cti = cti; bus.bte = bte;
        bus.we = w; bus.dat_w = d; bus.sel = 4'hF;
    endtask

    task automatic idle_bus();
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; bus.cti = 3'b000; bus.bte = 2'b00;
    endtask

    // One classic cycle: returns the wait-state response and the ack-cycle response.
    task automatic wb_classic(input logic [31:0] a, input logic w, input logic [31:0] d,
                              input logic [3:0] sl, output logic wait_resp, output logic ack,
                              output logic err, output logic [31:0] rd);
        drive(a, CLASSIC, LINEAR, w, d);
        bus.sel = sl;
        @(negedge clk);
        wait_resp = bus.ack | bus.err;
        step();
        @(negedge clk);
        ack = bus.ack; err = bus.err; rd = bus.dat_r;
        step();
        idle_bus();
        step();
    endtask

    task automatic test_reset();
        idle_bus();
        bus.adr = '0; bus.dat_w = '0; bus.sel = '0;
        rst = 1'b1;
        step();
        step();
        @(negedge clk);
        checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", bus.ack); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err); end
        checks++; if (bus.dat_r !== 32'h0) begin errors++; $display("FAIL reset_dat: got %h expected 0", bus.dat_r); end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_classic();
        logic w, a, e;
        logic [31:0] r;
        wb_classic(Base + 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, w, a, e, r);
        checks++; if (w !== 1'b0) begin errors++; $display("FAIL wr_wait: got %b expected 0", w); end
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL wr_ack: got %b expected 1", a); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL wr_err: got %b expected 0", e); end
        wb_classic(Base + 32'h10, 1'b0, 32'h0, 4'hF, w, a, e, r);
        checks++; if (w !== 1'b0) begin errors++; $display("FAIL rd_wait: got %b expected 0", w); end
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL rd_ack: got %b expected 1", a); end
        checks++; if (r !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_dat: got %h expected deadbeef", r); end
    endtask

    task automatic test_sel();
        logic w, a, e;
        logic [31:0] r;
        wb_classic(Base + 32'h10, 1'b1, 32'h11223344, 4'b0101, w, a, e, r);
        wb_classic(Base + 32'h10, 1'b0, 32'h0, 4'hF, w, a, e, r);
        checks++; if (r !== 32'hDE22BE44) begin errors++; $display("FAIL sel_dat: got %h expected de22be44", r); end
        wb_classic(Base + 32'h10, 1'b1, 32'hFFFFFFFF, 4'b0000, w, a, e, r);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL sel0_ack: got %b expected 1", a); end
        wb_classic(Base + 32'h10, 1'b0, 32'h0, 4'hF, w, a, e, r);
        checks++; if (r !== 32'hDE22BE44) begin errors++; $display("FAIL sel0_dat: got %h expected de22be44", r); end
    endtask

    task automatic test_back_to_back();
        drive(Base + 32'h10, CLASSIC, LINEAR, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus.ack !== 1'(i % 2)) begin
                errors++; $display("FAIL b2b_ack%0d: got %b expected %0d", i, bus.ack, i % 2);
            end
            step();
        end
        idle_bus();
        step();
    endtask

    task automatic preload();
        logic w, a, e;
        logic [31:0] r;
        for (int i = 0; i < 24; i++) begin
            wb_classic(Base + 32'(4 * i), 1'b1, 32'hA000_0000 + 32'(i), 4'hF, w, a, e, r);
        end
    endtask

    task automatic test_incr_burst();
        drive(Base, INCR, LINEAR, 1'b0, 32'h0);
        @(negedge clk);
        checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL incr_wait: got %b expected 0", bus.ack); end
        step();
        for (int k = 0; k < 4; k++) begin
            drive(Base + 32'(4 * k), (k == 3) ? END : INCR, LINEAR, 1'b0, 32'h0);
            @(negedge clk);
            checks++; if (bus.ack !== 1'b1) begin errors++; $display("FAIL incr_ack%0d: got %b expected 1", k, bus.ack); end
            checks++;
            if (bus.dat_r !== 32'hA000_0000 + 32'(k)) begin
                errors++; $display("FAIL incr_dat%0d: got %h expected %h", k, bus.dat_r, 32'hA000_0000 + 32'(k));
            end
            step();
        end
        drive(Base + 32'h10, CLASSIC, LINEAR, 1'b0, 32'h0);
        @(negedge clk);
        checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL incr_tail: got %b expected 0", bus.ack); end
        step();
        idle_bus();
        step();
    endtask

    task automatic test_wrap4();
        int unsigned w4 [4] = '{6, 7, 4, 5};
        drive(Base + 32'd24, INCR, WRAP4, 1'b0, 32'h0);
        @(negedge clk);
        checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL wrap_wait: got %b expected 0", bus.ack); end
        step();
        for (int k = 0; k < 4; k++) begin
            drive(Base + 32'(4 * w4[k]), (k == 3) ? END : INCR, WRAP4, 1'b0, 32'h0);
            @(negedge clk);
            checks++; if (bus.ack !== 1'b1) begin errors++; $display("FAIL wrap_ack%0d: got %b expected 1", k, bus.ack); end
            checks++;
            if (bus.dat_r !== 32'hA000_0000 + 32'(w4[k])) begin
                errors++; $display("FAIL wrap_dat%0d: got %h expected %h", k, bus.dat_r, 32'hA000_0000 + 32'(w4[k]));
            end
            step();
        end
        idle_bus();
        step();
        // Master strays to word 8 where the wrap predicts word 4.
        drive(Base + 32'd24, INCR, WRAP4, 1'b0, 32'h0);
        step();
        drive(Base + 32'd24, INCR, WRAP4, 1'b0, 32'h0);
        step();
        drive(Base + 32'd28, INCR, WRAP4, 1'b0, 32'h0);
        step();
        drive(Base + 32'd32, INCR, WRAP4, 1'b0, 32'h0);
        step();
        @(negedge clk);
        checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL wrap_abort_ack: got %b expected 0", bus.ack); end
        step();
        drive(Base + 32'd32, END, WRAP4, 1'b0, 32'h0);
        @(negedge clk);
        checks++; if (bus.ack !== 1'b1) begin errors++; $display("FAIL wrap_reentry_ack: got %b expected 1", bus.ack); end
        checks++; if (bus.dat_r !== 32'hA000_0008) begin errors++; $display("FAIL wrap_reentry_dat: got %h expected a0000008", bus.dat_r); end
        step();
        idle_bus();
        @(negedge clk);
        checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL wrap_end_ack: got %b expected 0", bus.ack); end
        step();
    endtask

    task automatic test_error();
        logic w, a, e;
        logic [31:0] r;
        wb_classic(OutOfRange, 1'b0, 32'h0, 4'hF, w, a, e, r);
        checks++; if (w !== 1'b0) begin errors++; $display("FAIL oor_wait: got %b expected 0", w); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL oor_err: got %b expected 1", e); end
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL oor_ack: got %b expected 0", a); end
        wb_classic(OutOfRange, 1'b1, 32'h55AA55AA, 4'hF, w, a, e, r);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL oor_wr_err: got %b expected 1", e); end
        wb_classic(Base - 32'd4, 1'b0, 32'h0, 4'hF, w, a, e, r);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL below_err: got %b expected 1", e); end
        wb_classic(Base, 1'b0, 32'h0, 4'hF, w, a, e, r);
        checks++; if (r !== 32'hA000_0000) begin errors++; $display("FAIL oor_nowrite: got %h expected a0000000", r); end
        drive(OutOfRange, INCR, LINEAR, 1'b0, 32'h0);
        step();
        drive(OutOfRange, INCR, LINEAR, 1'b0, 32'h0);
        @(negedge clk);
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL oor_burst_err: got %b expected 1", bus.err); end
        checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL oor_burst_ack: got %b expected 0", bus.ack); end
        step();
        drive(OutOfRange + 32'd4, INCR, LINEAR, 1'b0, 32'h0);
        @(negedge clk);
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL oor_burst_err2: got %b expected 0", bus.err); end
        step();
        idle_bus();
        step();
    endtask

    task automatic test_abort();
        logic w, a, e;
        logic [31:0] r;
        drive(Base + 32'd64, INCR, LINEAR, 1'b1, 32'hB000_0000);
        step();
        for (int k = 0; k < 2; k++) begin
            drive(Base + 32'd64 + 32'(4 * k), INCR, LINEAR, 1'b1, 32'hB000_0000 + 32'(k));
            @(negedge clk);
            checks++; if (bus.ack !== 1'b1) begin errors++; $display("FAIL wburst_ack%0d: got %b expected 1", k, bus.ack); end
            step();
        end
        drive(Base + 32'd72, INCR, LINEAR, 1'b1, 32'hB000_0002);
        bus.cyc = 1'b0;
        @(negedge clk);
        checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL drop_ack: got %b expected 0", bus.ack); end
        step();
        idle_bus();
        @(negedge clk);
        checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL drop_ack2: got %b expected 0", bus.ack); end
        step();
        wb_classic(Base + 32'd64, 1'b0, 32'h0, 4'hF, w, a, e, r);
        checks++; if (r !== 32'hB000_0000) begin errors++; $display("FAIL drop_w16: got %h expected b0000000", r); end
        wb_classic(Base + 32'd68, 1'b0, 32'h0, 4'hF, w, a, e, r);
        checks++; if (r !== 32'hB000_0001) begin errors++; $display("FAIL drop_w17: got %h expected b0000001", r); end
        wb_classic(Base + 32'd72, 1'b0, 32'h0, 4'hF, w, a, e, r);
        checks++; if (r !== 32'hA000_0012) begin errors++; $display("FAIL drop_w18: got %h expected a0000012", r); end
        // Reset in the middle of a read burst.
        drive(Base, INCR, LINEAR, 1'b0, 32'h0);
        step();
        for (int k = 0; k < 2; k++) begin
            drive(Base + 32'(4 * k), INCR, LINEAR, 1'b0, 32'h0);
            @(negedge clk);
            checks++; if (bus.ack !== 1'b1) begin errors++; $display("FAIL rburst_ack%0d: got %b expected 1", k, bus.ack); end
            step();
        end
        drive(Base + 32'd8, INCR, LINEAR, 1'b0, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b expected 0", bus.ack); end
        checks++; if (bus.dat_r !== 32'h0) begin errors++; $display("FAIL rst_dat: got %h expected 0", bus.dat_r); end
        step();
        drive(Base + 32'd8, END, LINEAR, 1'b0, 32'h0);
        @(negedge clk);
        checks++; if (bus.ack !== 1'b1) begin errors++; $display("FAIL rst_reentry_ack: got %b expected 1", bus.ack); end
        checks++; if (bus.dat_r !== 32'hA000_0002) begin errors++; $display("FAIL rst_reentry_dat: got %h expected a0000002", bus.dat_r); end
        step();
        idle_bus();
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle_bus();
        test_reset();
        test_classic();
        test_sel();
        test_back_to_back();
        preload();
        test_incr_burst();
        test_wrap4();
        test_error();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
